// File: rtl/ac_scan_ctrl.sv
// ac_scan_ctrl: Aho-Corasick scan sequencer issuing goto lookups and following failure links.
module ac_scan_ctrl #(
  parameter int CHAR_W   = 4,
  parameter int STATE_W  = 8,
  parameter int POS_W    = 16,
  parameter int MAX_FAIL = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_char_valid,
  input  logic [CHAR_W-1:0]  i_char_in,
  output logic               o_char_ready,
  output logic               o_goto_req,
  output logic [STATE_W-1:0] o_goto_state,
  output logic [CHAR_W-1:0]  o_goto_char,
  input  logic               i_goto_ack,
  input  logic               i_goto_hit,
  input  logic [STATE_W-1:0] i_goto_next,
  input  logic               i_goto_out,
  output logic               o_fail_req,
  output logic [STATE_W-1:0] o_fail_state,
  input  logic               i_fail_ack,
  input  logic [STATE_W-1:0] i_fail_next,
  output logic               o_match_valid,
  output logic [STATE_W-1:0] o_match_state,
  output logic [POS_W-1:0]   o_match_pos,
  output logic               o_busy,
  output logic               o_err
);
  localparam int CNT_W = $clog2(MAX_FAIL + 2);
  typedef enum logic [1:0] {IDLE, GOTO_WAIT, FAIL_WAIT} state_t;
  state_t             r_state, w_state;
  logic [STATE_W-1:0] r_cur, w_cur, r_ms, w_ms;
  logic [POS_W-1:0]   r_pos, w_pos, r_mp, w_mp;
  logic [CNT_W-1:0]   r_cnt, w_cnt, w_inc;
  logic [CHAR_W-1:0]  r_char, w_char;
  logic               r_greq, w_greq, r_freq, w_freq, r_rdy, r_mv, w_mv, r_err, w_err;

  always_comb begin
    w_state = r_state;
    w_cur   = r_cur;
    w_pos   = r_pos;
    w_cnt   = r_cnt;
    w_char  = r_char;
    w_greq  = r_greq;
    w_freq  = r_freq;
    w_mv    = 1'b0;
    w_ms    = r_ms;
    w_mp    = r_mp;
    w_err   = r_err;
    w_inc   = r_cnt + CNT_W'(1);
    if (i_start) begin
      w_state = IDLE;
      w_cur   = '0;
      w_pos   = '0;
      w_cnt   = '0;
      w_err   = 1'b0;
      w_greq  = 1'b0;
      w_freq  = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_char_valid && r_rdy) begin
          w_char  = i_char_in;
          w_cnt   = '0;
          w_greq  = 1'b1;
          w_state = GOTO_WAIT;
        end
        GOTO_WAIT: if (i_goto_ack) begin
          w_greq = 1'b0;
          if (i_goto_hit) begin
            w_cur   = i_goto_next;
            w_pos   = r_pos + POS_W'(1);
            w_state = IDLE;
            w_mv    = i_goto_out;
            w_ms    = i_goto_out ? i_goto_next : r_ms;
            w_mp    = i_goto_out ? r_pos : r_mp;
          end else if (r_cur == '0) begin
            w_pos   = r_pos + POS_W'(1);
            w_state = IDLE;
          end else begin
            w_freq  = 1'b1;
            w_state = FAIL_WAIT;
          end
        end
        FAIL_WAIT: if (i_fail_ack) begin
          w_freq = 1'b0;
          w_cnt  = w_inc;
          if (w_inc > CNT_W'(MAX_FAIL)) begin
            w_err   = 1'b1;
            w_cur   = '0;
            w_pos   = r_pos + POS_W'(1);
            w_state = IDLE;
          end else begin
            w_cur   = i_fail_next;
            w_greq  = 1'b1;
            w_state = GOTO_WAIT;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_pos   <= '0;
      r_cnt   <= '0;
      r_char  <= '0;
      r_greq  <= 1'b0;
      r_freq  <= 1'b0;
      r_rdy   <= 1'b0;
      r_mv    <= 1'b0;
      r_ms    <= '0;
      r_mp    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cur   <= w_cur;
      r_pos   <= w_pos;
      r_cnt   <= w_cnt;
      r_char  <= w_char;
      r_greq  <= w_greq;
      r_freq  <= w_freq;
      r_rdy   <= (w_state == IDLE);
      r_mv    <= w_mv;
      r_ms    <= w_ms;
      r_mp    <= w_mp;
      r_err   <= w_err;
    end
  end

  assign o_char_ready  = r_rdy;
  assign o_goto_req    = r_greq;
  assign o_goto_state  = r_cur;
  assign o_goto_char   = r_char;
  assign o_fail_req    = r_freq;
  assign o_fail_state  = r_cur;
  assign o_match_valid = r_mv;
  assign o_match_state = r_ms;
  assign o_match_pos   = r_mp;
  assign o_busy        = (r_state != IDLE);
  assign o_err         = r_err;
endmodule

// File: tb/tb_ac_scan_ctrl.sv
// tb_ac_scan_ctrl: directed bench with a he/she/his/hers table responder.
module tb_ac_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] cv = 2'b00, rdy, greq, gack, ghit, gout, freq, fack, mv, busy, err;
  logic [3:0] cin[2], gch[2];
  logic [7:0] gst[2], gnx[2], fst[2], fnx[2], ms[2];
  logic [15:0] mp[2];
  int nc = 0, nm = 0, nfreq = 0;
  bit rnd = 0, ghold = 0, fhold = 0;
  logic fack_m = 1'b0;
  logic [7:0] fnx_m = 8'd0;
  int gcnt[2] = '{0, 0}, glat[2] = '{1, 1}, fcnt[2] = '{0, 0}, flat[2] = '{1, 1};
  logic [23:0] mq0[$], mq1[$];

  ac_scan_ctrl u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_char_valid(cv[0]), .i_char_in(cin[0]),
    .o_char_ready(rdy[0]), .o_goto_req(greq[0]), .o_goto_state(gst[0]), .o_goto_char(gch[0]),
    .i_goto_ack(gack[0]), .i_goto_hit(ghit[0]), .i_goto_next(gnx[0]), .i_goto_out(gout[0]),
    .o_fail_req(freq[0]), .o_fail_state(fst[0]), .i_fail_ack(fack[0]), .i_fail_next(fnx[0]),
    .o_match_valid(mv[0]), .o_match_state(ms[0]), .o_match_pos(mp[0]), .o_busy(busy[0]), .o_err(err[0]));

  ac_scan_ctrl #(.MAX_FAIL(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_char_valid(cv[1]), .i_char_in(cin[1]),
    .o_char_ready(rdy[1]), .o_goto_req(greq[1]), .o_goto_state(gst[1]), .o_goto_char(gch[1]),
    .i_goto_ack(gack[1]), .i_goto_hit(ghit[1]), .i_goto_next(gnx[1]), .i_goto_out(gout[1]),
    .o_fail_req(freq[1]), .o_fail_state(fst[1]), .i_fail_ack(fack[1]), .i_fail_next(fnx[1]),
    .o_match_valid(mv[1]), .o_match_state(ms[1]), .o_match_pos(mp[1]), .o_busy(busy[1]), .o_err(err[1]));

  function automatic logic [9:0] gto(input logic [7:0] s, input logic [3:0] c);
    case ({s, c})
      12'h001: return {2'b10, 8'd1};
      12'h003: return {2'b10, 8'd3};
      12'h012: return {2'b11, 8'd2};
      12'h014: return {2'b10, 8'd6};
      12'h025: return {2'b10, 8'd8};
      12'h031: return {2'b10, 8'd4};
      12'h042: return {2'b11, 8'd5};
      12'h063: return {2'b11, 8'd7};
      12'h083: return {2'b11, 8'd9};
      default: return 10'd0;
    endcase
  endfunction

  // Instance 1 uses the altered table where 2 fails to 1, forming the chain 5->2->1.
  function automatic logic [7:0] fl(input logic [7:0] s, input bit m);
    case (s)
      8'd4: return 8'd1;
      8'd5: return 8'd2;
      8'd7, 8'd9: return 8'd3;
      8'd2: return m ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      gack[d] = 1'b0; ghit[d] = 1'b0; gout[d] = 1'b0; gnx[d] = 8'd0;
      fack[d] = 1'b0; fnx[d] = 8'd0;
      if (greq[d] && !(d == 0 && ghold)) begin
        if (gcnt[d] >= glat[d]) begin
          {ghit[d], gout[d], gnx[d]} = gto(gst[d], gch[d]);
          gack[d] = 1'b1;
          gcnt[d] = 0;
          glat[d] = rnd ? int'($urandom_range(0, 4)) : 1;
        end else gcnt[d]++;
      end else gcnt[d] = 0;
      if (d == 0 && fhold) begin
        fack[d] = fack_m;
        fnx[d] = fnx_m;
      end else if (freq[d]) begin
        if (fcnt[d] >= flat[d]) begin
          fnx[d] = fl(fst[d], d == 1);
          fack[d] = 1'b1;
          fcnt[d] = 0;
          flat[d] = rnd ? int'($urandom_range(0, 4)) : 1;
        end else fcnt[d]++;
      end else fcnt[d] = 0;
    end
  end

  always @(negedge clk) begin
    if (mv[0]) mq0.push_back({ms[0], mp[0]});
    if (mv[1]) mq1.push_back({ms[1], mp[1]});
    if (freq[0]) nfreq++;
  end

  task automatic send(input int d, input logic [3:0] c);
    int n = 0;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    cv[d] = 1'b1;
    cin[d] = c;
    while (!(rdy[d] && cv[d]) && n < 100) begin
      @(negedge clk);
      n++;
      cv[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (n >= 100) begin nc++; nm++; $display("FAIL send_timeout: dut %0d char %0d not accepted", d, c); end
    @(negedge clk);
    cv[d] = 1'b0;
  endtask

  task automatic send_str(input int d, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send(d, v[4*(n-1-i) +: 4]);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while ((busy[d] || !rdy[d]) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin nc++; nm++; $display("FAIL idle_timeout: dut %0d still busy", d); end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nc++; if ({rdy[0], greq[0], freq[0], mv[0], busy[0], err[0]} !== 6'b0) begin nm++; $display("FAIL reset_flags: got %b want 000000", {rdy[0], greq[0], freq[0], mv[0], busy[0], err[0]}); end
    nc++; if (gst[0] !== 8'd0) begin nm++; $display("FAIL reset_state: got %0d want 0", gst[0]); end
    nc++; if ({ms[0], mp[0]} !== 24'd0) begin nm++; $display("FAIL reset_match: got %h want 0", {ms[0], mp[0]}); end
    rst = 1'b0;
    @(negedge clk);
    nc++; if (rdy[0] !== 1'b1) begin nm++; $display("FAIL ready_after_reset: got %b want 1", rdy[0]); end
  endtask

  task automatic test_ushers(input bit r, input string nmz);
    int b;
    rnd = r;
    pulse_start();
    b = mq0.size();
    send_str(0, 32'h631253, 6);
    wait_idle(0);
    rnd = 0;
    nc++; if (mq0.size() - b !== 2) begin nm++; $display("FAIL %s_count: got %0d want 2", nmz, mq0.size() - b); end
    nc++; if (mq0[b] !== {8'd5, 16'd3}) begin nm++; $display("FAIL %s_m0: got %h want 050003", nmz, mq0[b]); end
    nc++; if (mq0[b+1] !== {8'd9, 16'd5}) begin nm++; $display("FAIL %s_m1: got %h want 090005", nmz, mq0[b+1]); end
    nc++; if (gst[0] !== 8'd9) begin nm++; $display("FAIL %s_final: got %0d want 9", nmz, gst[0]); end
    nc++; if ({mv[0], ms[0], mp[0]} !== {1'b0, 8'd9, 16'd5}) begin nm++; $display("FAIL %s_hold: got %h want 0090005", nmz, {mv[0], ms[0], mp[0]}); end
  endtask

  task automatic test_root_miss();
    int b, f;
    pulse_start();
    f = nfreq;
    b = mq0.size();
    send_str(0, 32'h66, 2);
    wait_idle(0);
    nc++; if (nfreq !== f) begin nm++; $display("FAIL root_freq: got %0d cycles want 0", nfreq - f); end
    nc++; if (gst[0] !== 8'd0) begin nm++; $display("FAIL root_state: got %0d want 0", gst[0]); end
    send_str(0, 32'h12, 2);
    wait_idle(0);
    nc++; if (mq0.size() - b !== 1) begin nm++; $display("FAIL root_count: got %0d want 1", mq0.size() - b); end
    nc++; if (mq0[b] !== {8'd2, 16'd3}) begin nm++; $display("FAIL root_pos: got %h want 020003", mq0[b]); end
  endtask

  task automatic test_max_fail();
    int b;
    pulse_start();
    b = mq1.size();
    send_str(1, 32'h3126, 4);
    wait_idle(1);
    nc++; if (err[1] !== 1'b1) begin nm++; $display("FAIL maxfail_err: got %b want 1", err[1]); end
    nc++; if (gst[1] !== 8'd0) begin nm++; $display("FAIL maxfail_state: got %0d want 0", gst[1]); end
    send_str(1, 32'h12, 2);
    wait_idle(1);
    nc++; if (mq1.size() - b !== 2) begin nm++; $display("FAIL maxfail_count: got %0d want 2", mq1.size() - b); end
    nc++; if (mq1[b] !== {8'd5, 16'd2}) begin nm++; $display("FAIL maxfail_m0: got %h want 050002", mq1[b]); end
    nc++; if (mq1[b+1] !== {8'd2, 16'd5}) begin nm++; $display("FAIL maxfail_m1: got %h want 020005", mq1[b+1]); end
    nc++; if (err[1] !== 1'b1) begin nm++; $display("FAIL maxfail_sticky: got %b want 1", err[1]); end
  endtask

  task automatic test_start_fail();
    int b, n = 0;
    pulse_start();
    nc++; if (err[1] !== 1'b0) begin nm++; $display("FAIL start_clears_err: got %b want 0", err[1]); end
    fhold = 1;
    send_str(0, 32'h3126, 4);
    while (!freq[0] && n < 50) begin @(negedge clk); n++; end
    nc++; if (freq[0] !== 1'b1) begin nm++; $display("FAIL start_freq_seen: got %b want 1", freq[0]); end
    b = mq0.size();
    pulse_start();
    nc++; if ({greq[0], freq[0], busy[0]} !== 3'b0) begin nm++; $display("FAIL start_drop: got %b want 000", {greq[0], freq[0], busy[0]}); end
    fack_m = 1'b1;
    fnx_m = 8'd2;
    repeat (3) @(negedge clk);
    fack_m = 1'b0;
    fhold = 0;
    @(negedge clk);
    nc++; if ({gst[0], busy[0], err[0]} !== 10'd0) begin nm++; $display("FAIL start_ack_ignored: got %h want 0", {gst[0], busy[0], err[0]}); end
    nc++; if (mq0.size() !== b) begin nm++; $display("FAIL start_no_match: got %0d want 0", mq0.size() - b); end
    send_str(0, 32'h12, 2);
    wait_idle(0);
    nc++; if (mq0[b] !== {8'd2, 16'd1}) begin nm++; $display("FAIL start_pos_reset: got %h want 020001", mq0[b]); end
  endtask

  task automatic test_rst_mid();
    int b;
    ghold = 1;
    send(0, 4'd3);
    nc++; if (greq[0] !== 1'b1) begin nm++; $display("FAIL rst_greq_pending: got %b want 1", greq[0]); end
    #2 rst = 1'b1;
    #1;
    nc++; if ({rdy[0], greq[0], freq[0], mv[0], busy[0], err[0]} !== 6'b0) begin nm++; $display("FAIL rst_async_flags: got %b want 000000", {rdy[0], greq[0], freq[0], mv[0], busy[0], err[0]}); end
    nc++; if ({gch[0], ms[0], mp[0]} !== 28'd0) begin nm++; $display("FAIL rst_async_regs: got %h want 0", {gch[0], ms[0], mp[0]}); end
    @(negedge clk);
    rst = 1'b0;
    ghold = 0;
    b = mq0.size();
    send_str(0, 32'h12, 2);
    wait_idle(0);
    nc++; if (mq0.size() - b !== 1) begin nm++; $display("FAIL rst_resume_count: got %0d want 1", mq0.size() - b); end
    nc++; if (mq0[b] !== {8'd2, 16'd1}) begin nm++; $display("FAIL rst_resume: got %h want 020001", mq0[b]); end
  endtask

  initial begin
    cin[0] = 4'd0;
    cin[1] = 4'd0;
    test_reset();
    test_ushers(0, "ushers");
    test_ushers(1, "random");
    test_root_miss();
    test_max_fail();
    test_start_fail();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
